muldiv_iter: RTL and testbench



---
 rtl/muldiv_pkg.sv | 14 +
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_iter.sv | 141 ++++++++++++++
 tb/tb_muldiv_iter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM state encoding and op codes.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply on {acc, multiplier} or restoring
// shift-subtract divide on {rem, quotient}; purely combinational.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_upper,
    output logic [WIDTH-1:0] next_lower
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum        = {1'b0, upper} + (lower[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Remainder gets one extra bit so the shifted partial remainder cannot overflow.
        shifted    = {upper, lower[WIDTH-1]};
        diff       = shifted - {1'b0, operand};
        next_upper = upper;
        next_lower = lower;
        if (op == OP_MULT) begin
            next_upper = sum[WIDTH:1];
            next_lower = {sum[0], lower[WIDTH-1:1]};
        end else begin
            next_upper = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            next_lower = {lower[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed multiply/divide engine with start/done handshake feeding Hi/Lo.
// Optional MULDIV_UNSIGNED_EN adds the is_unsigned port for multu/divu.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] upper_q;
    logic [WIDTH-1:0] lower_q;
    logic [WIDTH-1:0] step_upper;
    logic [WIDTH-1:0] step_lower;
    logic             signed_mode;
    logic             zero_div;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic en);
        return (en && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return -x;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_pair(input logic [2*WIDTH-1:0] x);
        return -x;
    endfunction

`ifdef MULDIV_UNSIGNED_EN
    assign signed_mode = ~is_unsigned;
`else
    assign signed_mode = 1'b1;
`endif

    assign zero_div = (op == OP_DIV) && (b == '0);
    assign busy     = (state != IDLE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op         (op_q),
        .upper      (upper_q),
        .lower      (lower_q),
        .operand    (operand_q),
        .next_upper (step_upper),
        .next_lower (step_lower)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = zero_div ? DONE : RUN;
            RUN:  if (count == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            op_q      <= OP_MULT;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            operand_q <= '0;
            upper_q   <= '0;
            lower_q   <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Signs are zeroed in unsigned mode so FIX naturally skips correction.
                        op_q      <= op;
                        sign_a_q  <= signed_mode & a[WIDTH-1];
                        sign_b_q  <= signed_mode & b[WIDTH-1];
                        operand_q <= magnitude(b, signed_mode);
                        upper_q   <= '0;
                        lower_q   <= magnitude(a, signed_mode);
                        div_zero  <= zero_div;
                        count     <= zero_div ? '0 : CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    upper_q <= step_upper;
                    lower_q <= step_lower;
                    count   <= count - CNT_W'(1);
                end
                FIX: begin
                    if (op_q == OP_MULT) begin
                        if (sign_a_q ^ sign_b_q)
                            {upper_q, lower_q} <= negate_pair({upper_q, lower_q});
                    end else begin
                        // Quotient truncates toward zero; remainder follows the dividend.
                        if (sign_a_q ^ sign_b_q) lower_q <= negate(lower_q);
                        if (sign_a_q)            upper_q <= negate(upper_q);
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    if (!div_zero) begin
                        hi <= upper_q;
                        lo <= lower_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_iter;

    localparam int W = 32;
`ifdef MULDIV_UNSIGNED_EN
    localparam logic UNS_EN = 1'b1;
`else
    localparam logic UNS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef MULDIV_UNSIGNED_EN
    logic         is_unsigned;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] ref_hi = '0;
    logic [W-1:0] ref_lo = '0;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
`ifdef MULDIV_UNSIGNED_EN
        .is_unsigned (is_unsigned),
`endif
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_zero    (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  input logic uns, output logic [W-1:0] eh,
                                  output logic [W-1:0] el, output logic edz);
        longint         sa, sb, q, r;
        logic [2*W-1:0] prod;
        sa  = longint'($signed(aa));
        sb  = longint'($signed(bb));
        edz = 1'b0;
        eh  = ref_hi;
        el  = ref_lo;
        if (o == 1'b0) begin
            if (uns) prod = {{W{1'b0}}, aa} * {{W{1'b0}}, bb};
            else     prod = 64'(sa * sb);
            {eh, el} = prod;
        end else if (bb == '0) begin
            edz = 1'b1;
        end else if (uns) begin
            el = aa / bb;
            eh = aa % bb;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            el = q[W-1:0];
            eh = r[W-1:0];
        end
    endfunction

    // glitch_at >= 0 pulses start that many cycles after acceptance (must be ignored).
    task automatic do_op(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic uns, input int glitch_at);
        logic [W-1:0] eh, el;
        logic         edz;
        int           lat, busy_bad, exp_lat;
        bit           got;
        model(o, aa, bb, uns & UNS_EN, eh, el, edz);
        exp_lat = edz ? 1 : W + 2;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
`ifdef MULDIV_UNSIGNED_EN
        is_unsigned = uns;
`endif
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
        busy_bad = (busy !== 1'b1) ? 1 : 0;
        lat = 0; got = 0;
        while (!got && lat < 100) begin
            if (lat == glitch_at) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done === 1'b1) got = 1;
            else if (busy !== 1'b1) busy_bad++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_while_active", 64'(busy_bad), 64'd0);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("hi", {32'd0, hi}, {32'd0, eh});
        check("lo", {32'd0, lo}, {32'd0, el});
        check("div_zero", {63'd0, div_zero}, {63'd0, edz});
        @(posedge clk); #1;
        check("done_one_pulse", {63'd0, done}, 64'd0);
        check("idle_after_done", {63'd0, busy}, 64'd0);
        ref_hi = eh;
        ref_lo = el;
    endtask

    initial begin
        int dones;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
`ifdef MULDIV_UNSIGNED_EN
        is_unsigned = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_div_zero", {63'd0, div_zero}, 64'd0);
        @(negedge clk); reset = 1'b0;

        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, -1);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        do_op(1'b1, 32'd5, 32'd0, 1'b0, -1);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        do_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0, 5);
        do_op(1'b0, 32'd12345, 32'hFFFF_F000, 1'b0, W + 1);

        // Reset ten cycles into a divide: outputs clear, no done follows.
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        check("abort_div_zero", {63'd0, div_zero}, 64'd0);
        @(negedge clk); reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        ref_hi = '0;
        ref_lo = '0;

`ifdef MULDIV_UNSIGNED_EN
        do_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, -1);
        do_op(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, -1);
`endif

        for (int i = 0; i < 30; i++) begin
            logic         ro, ru;
            logic [W-1:0] ra, rb;
            ro = 1'($urandom);
            ru = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, ru, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
